// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and instruction-memory write port of the program loader
// master is the loader side; slave is the byte source / memory side.
interface prog_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads instruction memory from a length-prefixed little-endian byte stream
// The core is held in reset until a complete image has been written.
module prog_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   prog_loader_if.master     bus,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } state_t;

   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

   state_t              r_state;
   state_t              w_next;
   logic [15:0]         r_len;
   logic [1:0]          r_byte_idx;
   logic [23:0]         r_word;
   logic [31:0]         r_wdata;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_words;

   logic                w_accept;
   logic [15:0]         w_len_full;
   logic [ADDR_W:0]     w_words_inc;
   logic                w_last_word;
   logic                w_rx_ready;
   logic                w_imem_we;
   logic                w_core_rst;
   logic                w_busy;
   logic                w_done;
   logic                w_error;

   // rx_ready depends on registered state only, never on rx_valid.
   assign w_accept    = bus.rx_valid &&
                        (r_state == S_LEN_LO || r_state == S_LEN_HI || r_state == S_DATA);
   assign w_len_full  = {bus.rx_data, r_len[7:0]};
   assign w_words_inc = r_words + 1'b1;
   assign w_last_word = (17'(w_words_inc) == {1'b0, r_len});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_rx_ready = 1'b0;
      w_imem_we  = 1'b0;
      w_core_rst = 1'b1;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_error    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            w_rx_ready = 1'b1;
            w_busy     = 1'b1;
            if (bus.rx_valid) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            w_rx_ready = 1'b1;
            w_busy     = 1'b1;
            if (bus.rx_valid) begin
               if (w_len_full == 16'd0)                 w_next = S_DONE;
               else if ({1'b0, w_len_full} > CAPACITY)  w_next = S_ERROR;
               else                                     w_next = S_DATA;
            end
         end
         S_DATA: begin
            w_rx_ready = 1'b1;
            w_busy     = 1'b1;
            if (bus.rx_valid && r_byte_idx == 2'd3) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_imem_we = 1'b1;
            w_busy    = 1'b1;
            w_next    = w_last_word ? S_DONE : S_DATA;
         end
         S_DONE: begin
            w_core_rst = 1'b0;
            w_done     = 1'b1;
            if (start) w_next = S_LEN_LO;
         end
         S_ERROR: begin
            w_error = 1'b1;
            if (start) w_next = S_LEN_LO;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address and data are captured on the 4th byte so they stay stable outside WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len      <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_words    <= '0;
      end else begin
         case (r_state)
            S_DONE: begin
               if (start) r_words <= '0;
            end
            S_LEN_LO: begin
               if (w_accept) r_len[7:0] <= bus.rx_data;
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= bus.rx_data;
                  r_byte_idx  <= 2'd0;
                  r_words     <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  case (r_byte_idx)
                     2'd0: r_word[7:0]   <= bus.rx_data;
                     2'd1: r_word[15:8]  <= bus.rx_data;
                     2'd2: r_word[23:16] <= bus.rx_data;
                     default: begin
                        r_wdata <= {bus.rx_data, r_word};
                        r_addr  <= r_words[ADDR_W-1:0];
                     end
                  endcase
                  r_byte_idx <= r_byte_idx + 2'd1;
               end
            end
            S_WRITE: r_words <= w_words_inc;
            default: ;
         endcase
      end
   end

   assign bus.rx_ready   = w_rx_ready;
   assign bus.imem_we    = w_imem_we;
   assign bus.imem_addr  = 32'(r_addr);
   assign bus.imem_wdata = r_wdata;
   assign core_rst       = w_core_rst;
   assign busy           = w_busy;
   assign done           = w_done;
   assign error          = w_error;
   assign words_loaded   = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a stream-level model
// Expected writes are derived from the length and word list, not from the loader's states.
module tb_prog_loader;
   localparam int ADDR_W = 4;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   prog_loader_if bus ();

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];
   logic [31:0] stim_words[$];
   logic        prev_we   = 1'b0;
   logic        mon_ready = 1'b0;
   int          busy_cycles = 0;
   int          gap_max = 0;
   bit          start_noise = 1'b0;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         cap_addr.push_back(bus.imem_addr);
         cap_data.push_back(bus.imem_wdata);
         check_eq("we_rx_ready_low", 64'(bus.rx_ready), 64'd0);
         check_eq("we_single_cycle", 64'(prev_we), 64'd0);
      end
      prev_we   = bus.imem_we;
      mon_ready = bus.rx_ready;
      if (busy === 1'b1) busy_cycles++;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  g;
      bit  acc;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
         if (start_noise && $urandom_range(2, 0) == 0) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(posedge clk);
         acc = mon_ready;
         #1;
      end
      bus.rx_valid = 1'b0;
      if (!acc) check_eq("rx_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_load(input int n);
      int  n_data;
      bit  exp_err;
      bit  fin;
      exp_err = (n > CAP);
      n_data  = exp_err ? 0 : n;
      while (stim_words.size() < n_data) stim_words.push_back($urandom);
      cap_addr.delete();
      cap_data.delete();

      check_eq("ready_low_before_start", 64'(bus.rx_ready), 64'd0);
      pulse_start();
      busy_cycles = 0;
      check_eq("ready_after_start", 64'(bus.rx_ready), 64'd1);

      send_byte(8'(n));
      send_byte(8'(n >> 8));
      for (int i = 0; i < n_data; i++)
         for (int k = 0; k < 4; k++)
            send_byte(8'(stim_words[i] >> (8 * k)));

      fin = (done === 1'b1) || (error === 1'b1);
      for (int k = 0; k < 100 && !fin; k++) begin
         @(negedge clk);
         fin = (done === 1'b1) || (error === 1'b1);
      end
      if (!fin) check_eq("finish_timeout", 64'd0, 64'd1);
      @(negedge clk);

      check_eq("done",     64'(done),        64'(!exp_err));
      check_eq("error",    64'(error),       64'(exp_err));
      check_eq("core_rst", 64'(core_rst),    64'(exp_err));
      check_eq("busy_end", 64'(busy),        64'd0);
      check_eq("ready_end", 64'(bus.rx_ready), 64'd0);
      if (!exp_err) check_eq("words_loaded", 64'(words_loaded), 64'(n));
      check_eq("write_count", 64'(cap_addr.size()), 64'(n_data));
      for (int i = 0; i < n_data && i < cap_addr.size(); i++) begin
         check_eq($sformatf("addr[%0d]", i), 64'(cap_addr[i]), 64'(i));
         check_eq($sformatf("data[%0d]", i), 64'(cap_data[i]), 64'(stim_words[i]));
      end
      if (gap_max == 0 && !exp_err)
         check_eq("full_rate_cycles", 64'(busy_cycles), 64'(2 + 5 * n));
      stim_words.delete();
   endtask

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_rx_ready"},  64'(bus.rx_ready),   64'd0);
      check_eq({pfx, "_imem_we"},   64'(bus.imem_we),    64'd0);
      check_eq({pfx, "_imem_addr"}, 64'(bus.imem_addr),  64'd0);
      check_eq({pfx, "_wdata"},     64'(bus.imem_wdata), 64'd0);
      check_eq({pfx, "_core_rst"},  64'(core_rst),       64'd1);
      check_eq({pfx, "_busy"},      64'(busy),           64'd0);
      check_eq({pfx, "_done"},      64'(done),           64'd0);
      check_eq({pfx, "_error"},     64'(error),          64'd0);
      check_eq({pfx, "_words"},     64'(words_loaded),   64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'd0;
      #1 check_reset_values("rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed two-word image, full rate.
      stim_words.push_back(32'h0000_0013);
      stim_words.push_back(32'hDEAD_BEEF);
      run_load(2);
      run_load(0);
      run_load(17);
      run_load(1);

      // Random gaps with ignored start pulses during the load.
      gap_max     = 3;
      start_noise = 1'b1;
      stim_words.push_back(32'h0000_0013);
      stim_words.push_back(32'hDEAD_BEEF);
      run_load(2);
      for (int r = 0; r < 4; r++) run_load(int'($urandom_range(CAP, 1)));
      gap_max     = 0;
      start_noise = 1'b0;

      // Asynchronous reset after six data bytes.
      pulse_start();
      send_byte(8'd2);
      send_byte(8'd0);
      for (int k = 0; k < 6; k++) send_byte(8'($urandom));
      #3 rst = 1'b1;
      #1 check_reset_values("midrst");
      @(posedge clk);
      #1 rst = 1'b0;
      run_load(2);

      run_load(CAP);

      for (int r = 0; r < 6; r++) begin
         gap_max = int'($urandom_range(2, 0));
         case ($urandom_range(3, 0))
            0:       run_load(0);
            1:       run_load(int'($urandom_range(65535, CAP + 1)));
            default: run_load(int'($urandom_range(CAP, 1)));
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the processor's instruction memory from a byte stream, then releases the core from reset. It is the writing end of the instruction-memory interface the core only reads: it sits between a byte source (UART receiver or testbench) and the instruction memory write port, and owns the core reset. Words are assembled little-endian and written to consecutive word addresses starting at 0.

## Interface
- ADDR_W, 8, instruction memory word-address width; capacity 2^ADDR_W words (ADDR_W ≤ 16)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  32  word address, zero-extended from ADDR_W bits
- imem_wdata  out  32  word to write
- core_rst  out  1  holds the processor in reset while high
- busy  out  1  a load is in progress
- done  out  1  last load completed
- error  out  1  last load rejected: length exceeds capacity
- words_loaded  out  ADDR_W+1  words written in the current or last load

## Operation
- Stream format: length N (16 bits, low byte first), then 4·N data bytes. Each word is bytes b0..b3 with b0 → wdata[7:0] and b3 → wdata[31:24].
- A byte transfers on a clk edge where rx_valid && rx_ready.
- States:
  - IDLE: rx_ready=0. start → LEN_LO.
  - LEN_LO: rx_ready=1. Byte → len[7:0] → LEN_HI.
  - LEN_HI: rx_ready=1. Byte → len[15:8]. Then N=0 → DONE; N > 2^ADDR_W → ERROR; otherwise → DATA with byte index 0 and words_loaded 0.
  - DATA: rx_ready=1. Each byte fills lane byte_idx, and byte_idx increments modulo 4. The 4th byte → WRITE.
  - WRITE: one cycle. imem_we=1, imem_addr=words_loaded, imem_wdata=assembled word, rx_ready=0. On exit, words_loaded increments. If it now equals N → DONE, else → DATA.
  - DONE: core_rst=0, done=1. start → LEN_LO, and clears done and words_loaded.
  - ERROR: error=1, core_rst=1, rx_ready=0. start → LEN_LO, and clears error.
- start in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- core_rst=1 in every state except DONE, so the core never runs a partial image.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- imem_addr and imem_wdata are held stable outside WRITE. They carry no meaning when imem_we=0.

## Timing
- Reset values:
  - state IDLE, rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - core_rst 1, busy 0, done 0, error 0, words_loaded 0
- Reset is asynchronous. Asserting it mid-load aborts immediately to IDLE with core_rst=1. A partially written memory is left as-is.
- All outputs are registered or decoded from registered state. There is no combinational path from rx_valid to rx_ready.
- start is sampled on clk. Pulse to LEN_LO is 1 cycle, so rx_ready rises the cycle after start.
- Latency for a data word:
  - the 4th byte accepted at edge t → imem_we high during cycle t+1
  - rx_ready low in that cycle, high again at t+2
- Full-rate stream, N words: 2 + 5·N cycles from the first byte accepted to entering DONE. core_rst falls in the cycle after the last write.
- rx_valid may drop between any bytes. State and partial word are held indefinitely; there is no timeout.
- N = 2^ADDR_W is legal and fills memory exactly. imem_addr reaches 2^ADDR_W−1 and does not wrap.
- words_loaded is ADDR_W+1 bits so it can represent the full count.

## Test plan
- Reset, start, stream 02 00 | 13 00 00 00 | EF BE AD DE:
  - writes addr0=0x00000013 and addr1=0xDEADBEEF
  - each imem_we pulse is 1 cycle
  - ends with done=1, core_rst=0, words_loaded=2
- Length 00 00 → DONE directly after LEN_HI, no imem_we, core_rst=0 one cycle later.
- ADDR_W=4, length 11 00 (17) → ERROR, error=1, rx_ready=0, core_rst=1; a following start with length 01 00 and one word succeeds.
- rx_valid toggling with random gaps, plus start pulses during the load → same writes as the full-rate case; extra starts have no effect.
- Async rst asserted after 6 data bytes → all outputs at reset values within the same cycle. A fresh load then writes from addr 0.
- ADDR_W=4, N=16 → 16 writes to addr 0..15, words_loaded=16, done=1.
